// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes and
// data-memory wait stalls with a sticky timeout flag and stall counter.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [4:0]  id_reg1_raddr_i,
   input  logic [4:0]  id_reg2_raddr_i,
   input  logic        id_reg1_re_i,
   input  logic        id_reg2_re_i,
   input  logic        exe_is_load_i,
   input  logic        exe_reg_we_i,
   input  logic [4:0]  exe_reg_waddr_i,
   input  logic        exe_jump_i,
   input  logic [31:0] exe_jump_addr_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic [3:0]  stall_o,
   output logic [1:0]  flush_o,
   output logic        pc_redirect_o,
   output logic [31:0] pc_redirect_addr_o,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cnt_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDUSE   = 2'd1,
      MEMWAIT = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   localparam logic [16:0] TO = 17'(TIMEOUT);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_wait_cnt;
   logic [15:0] r_stall_cnt;
   logic        r_err;
   logic        w_mem_wait;
   logic        w_hit1;
   logic        w_hit2;
   logic        w_hazard;
   logic [16:0] w_wait_inc;

   assign w_mem_wait = mem_req_i & ~mem_ack_i;
   assign w_hit1     = id_reg1_re_i & (id_reg1_raddr_i == exe_reg_waddr_i);
   assign w_hit2     = id_reg2_re_i & (id_reg2_raddr_i == exe_reg_waddr_i);
   assign w_hazard   = exe_is_load_i & exe_reg_we_i &
                       (exe_reg_waddr_i != 5'd0) & (w_hit1 | w_hit2);
   assign w_wait_inc = {1'b0, r_wait_cnt} + 17'd1;

   always_comb begin
      w_next             = r_state;
      stall_o            = 4'b0000;
      flush_o            = 2'b00;
      pc_redirect_o      = 1'b0;
      pc_redirect_addr_o = 32'd0;
      if (r_state == MEMWAIT) begin
         if (mem_ack_i) begin
            w_next = RUN;
         end else begin
            stall_o = 4'b1111;
         end
      end else if (w_mem_wait) begin
         stall_o = 4'b1111;
         w_next  = MEMWAIT;
      end else if (exe_jump_i) begin
         flush_o            = 2'b11;
         pc_redirect_o      = 1'b1;
         pc_redirect_addr_o = exe_jump_addr_i;
         w_next             = FLUSH;
      end else if (w_hazard && r_state != LDUSE) begin
         stall_o = 4'b0011;
         flush_o = 2'b10;
         w_next  = LDUSE;
      end else begin
         // FLUSH kills the fetch that was in flight when the jump resolved
         flush_o = (r_state == FLUSH) ? 2'b01 : 2'b00;
         w_next  = RUN;
      end
      if (!rst_n_i) begin
         stall_o            = 4'b0000;
         flush_o            = 2'b00;
         pc_redirect_o      = 1'b0;
         pc_redirect_addr_o = 32'd0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= RUN;
         r_wait_cnt  <= 16'd0;
         r_stall_cnt <= 16'd0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state != MEMWAIT) begin
            r_wait_cnt <= 16'd0;
         end else if (!mem_ack_i && r_wait_cnt != 16'hFFFF) begin
            r_wait_cnt <= w_wait_inc[15:0];
         end
         if (r_state == MEMWAIT && !mem_ack_i && w_wait_inc >= TO) begin
            r_err <= 1'b1;
         end
         if ((|stall_o) && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign state_o     = r_state;
   assign stall_cnt_o = r_stall_cnt;
   assign err_o       = r_err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl with TIMEOUT=4.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  r1a, r2a, wa;
   logic        r1e, r2e, ld, we, jmp, req, ack;
   logic [31:0] jaddr;
   logic [3:0]  stall;
   logic [1:0]  flush;
   logic        redir;
   logic [31:0] raddr;
   logic [1:0]  state;
   logic [15:0] scnt;
   logic        err;

   int n_vec = 0;
   int n_bad = 0;
   int m_cnt = 0;

   typedef struct {
      logic [3:0]  st;
      logic [1:0]  fl;
      logic        rd;
      logic [31:0] ad;
      logic [1:0]  ns;
      logic        er;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   pipe_ctrl #(.TIMEOUT(4)) dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .id_reg1_raddr_i    (r1a),
      .id_reg2_raddr_i    (r2a),
      .id_reg1_re_i       (r1e),
      .id_reg2_re_i       (r2e),
      .exe_is_load_i      (ld),
      .exe_reg_we_i       (we),
      .exe_reg_waddr_i    (wa),
      .exe_jump_i         (jmp),
      .exe_jump_addr_i    (jaddr),
      .mem_req_i          (req),
      .mem_ack_i          (ack),
      .stall_o            (stall),
      .flush_o            (flush),
      .pc_redirect_o      (redir),
      .pc_redirect_addr_o (raddr),
      .state_o            (state),
      .stall_cnt_o        (scnt),
      .err_o              (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // caller drives inputs at negedge; combinational outputs checked
   // mid-low-phase, registered state just after the next posedge
   task automatic run(input string tag, input logic [3:0] st,
                      input logic [1:0] fl, input logic rd,
                      input logic [31:0] ad, input logic [1:0] ns,
                      input logic er);
      exp_t e;
      e = '{st: st, fl: fl, rd: rd, ad: ad, ns: ns, er: er};
      q.push_back(e);
      #2;
      if (q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         chk({tag, "_stall"}, 32'(stall), 32'(e.st));
         chk({tag, "_flush"}, 32'(flush), 32'(e.fl));
         chk({tag, "_redir"}, 32'(redir), 32'(e.rd));
         chk({tag, "_raddr"}, raddr, e.ad);
         if (e.st != 4'd0 && m_cnt != 65535) m_cnt++;
         @(posedge clk);
         #1;
         chk({tag, "_state"}, 32'(state), 32'(e.ns));
         chk({tag, "_scnt"}, 32'(scnt), 32'(m_cnt));
         chk({tag, "_err"}, 32'(err), 32'(e.er));
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      r1a = 5'd5; r2a = 5'd5; wa = 5'd5;
      r1e = 1'b1; r2e = 1'b1; ld = 1'b1; we = 1'b1;
      jmp = 1'b1; jaddr = 32'hDEADBEEF; req = 1'b1; ack = 1'b0;
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_redir", 32'(redir), 32'd0);
      chk("rst_raddr", raddr, 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_scnt", 32'(scnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      r1a = 5'd0; r2a = 5'd0; wa = 5'd0;
      r1e = 1'b0; r2e = 1'b0; ld = 1'b0; we = 1'b0;
      jmp = 1'b0; req = 1'b0;
      run("idle", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b0);

      ld = 1'b1; we = 1'b1; wa = 5'd5; r2e = 1'b1; r2a = 5'd5;
      run("lu", 4'b0011, 2'b10, 1'b0, 32'd0, 2'd1, 1'b0);
      run("lu_sup", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b0);

      wa = 5'd0; r2a = 5'd0;
      run("x0", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b0);

      r1e = 1'b1; r1a = 5'd7; r2e = 1'b0; wa = 5'd7;
      run("lu_r1", 4'b0011, 2'b10, 1'b0, 32'd0, 2'd1, 1'b0);
      ld = 1'b0;
      run("lu_r1_end", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b0);

      ld = 1'b1; wa = 5'd5; r2e = 1'b1; r2a = 5'd5;
      jmp = 1'b1; jaddr = 32'h80000040;
      run("jmp", 4'b0000, 2'b11, 1'b1, 32'h80000040, 2'd3, 1'b0);
      jmp = 1'b0; ld = 1'b0; jaddr = 32'h12345678;
      run("flush", 4'b0000, 2'b01, 1'b0, 32'd0, 2'd0, 1'b0);

      req = 1'b1; jmp = 1'b1;
      run("mw1", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      ld = 1'b1;
      run("mw2", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      run("mw3", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      ack = 1'b1; jmp = 1'b0; ld = 1'b0;
      run("mw_ack", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b0);

      ack = 1'b0;
      run("to_in", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      run("to_1", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      run("to_2", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      run("to_3", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b0);
      run("to_4", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b1);
      run("to_5", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b1);
      ack = 1'b1;
      run("to_ack", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b1);
      req = 1'b0; ack = 1'b0;
      run("to_stick", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b1);

      req = 1'b1;
      run("ar_in", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b1);
      run("ar_mw", 4'b1111, 2'b00, 1'b0, 32'd0, 2'd2, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      m_cnt = 0;
      chk("ar_stall", 32'(stall), 32'd0);
      chk("ar_state", 32'(state), 32'd0);
      chk("ar_scnt", 32'(scnt), 32'd0);
      chk("ar_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      chk("ar_hold", 32'(state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; req = 1'b0;
      run("ar_rel", 4'b0000, 2'b00, 1'b0, 32'd0, 2'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum data-memory wait cycles before error (range 1..65535).
REQ-002 Clocking: one clock `clk_i`, rising edge; reset `rst_n_i` is asynchronous and active-low.
REQ-003 Port: clk_i  in  1  clock.
REQ-004 Port: rst_n_i  in  1  asynchronous active-low reset.
REQ-005 Ports id_reg1_raddr_i / id_reg2_raddr_i  in  5 each  ID-stage source register addresses.
REQ-006 Ports id_reg1_re_i / id_reg2_re_i  in  1 each  ID-stage read enables.
REQ-007 Port: exe_is_load_i  in  1  EX-stage instruction is a load.
REQ-008 Port: exe_reg_we_i  in  1  EX-stage writes a register.
REQ-009 Port: exe_reg_waddr_i  in  5  EX-stage destination register.
REQ-010 Port: exe_jump_i  in  1  EX-stage taken branch/jump.
REQ-011 Port: exe_jump_addr_i  in  32  jump target.
REQ-012 Port: mem_req_i  in  1  MEM-stage data access pending.
REQ-013 Port: mem_ack_i  in  1  data memory completes the access this cycle.
REQ-014 Port: stall_o  out  4  hold enables; [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM.
REQ-015 Port: flush_o  out  2  bubble insertion; [0] IF/ID, [1] ID/EX.
REQ-016 Port: pc_redirect_o  out  1  load PC from pc_redirect_addr_o.
REQ-017 Port: pc_redirect_addr_o  out  32  redirect target.
REQ-018 Port: state_o  out  2  current state; RUN=0, LDUSE=1, MEMWAIT=2, FLUSH=3.
REQ-019 Port: stall_cnt_o  out  16  saturating count of stall cycles.
REQ-020 Port: err_o  out  1  sticky memory-timeout flag.

Function
REQ-021 Outputs stall_o, flush_o, pc_redirect_o and pc_redirect_addr_o SHALL be combinational from the current state and inputs; the state and counters are registered.
REQ-022 Load-use hazard: exe_is_load_i & exe_reg_we_i & exe_reg_waddr_i!=0 & ((id_reg1_re_i & id_reg1_raddr_i==exe_reg_waddr_i) | (id_reg2_re_i & id_reg2_raddr_i==exe_reg_waddr_i)).
REQ-023 Memory wait: mem_wait = mem_req_i & ~mem_ack_i.
REQ-024 Priority in RUN, LDUSE and FLUSH: mem_wait > exe_jump_i > load-use hazard.
REQ-025 mem_wait: stall_o=4'b1111, flush_o=0, no redirect; next state MEMWAIT.
REQ-026 Jump, no mem_wait: flush_o=2'b11, pc_redirect_o=1, pc_redirect_addr_o=exe_jump_addr_i, stall_o=0; next state FLUSH.
REQ-027 Hazard only: stall_o=4'b0011, flush_o=2'b10; next state LDUSE.
REQ-028 No event: all control outputs 0; next state RUN.
REQ-029 LDUSE, one cycle, hazard detection suppressed: if no mem_wait/jump, outputs 0 and next state RUN.
REQ-030 FLUSH, one cycle, in-flight fetch killed: if no mem_wait/jump, flush_o=2'b01 and next state RUN.
REQ-031 MEMWAIT: stall_o=4'b1111 while mem_ack_i=0; jump and hazard inputs ignored.
REQ-032 MEMWAIT, ack cycle: mem_ack_i=1 gives stall_o=0 in that same cycle; next state RUN.
REQ-033 wait_cnt (16 bit) SHALL clear on MEMWAIT entry and increment each MEMWAIT cycle without ack.
REQ-034 err_o SHALL set when wait_cnt reaches TIMEOUT, then stay set until reset; the block remains in MEMWAIT.
REQ-035 stall_cnt_o SHALL increment each cycle with any stall_o bit set, saturating at 16'hFFFF.
REQ-036 pc_redirect_addr_o SHALL be 0 whenever pc_redirect_o=0.

Reset
REQ-037 rst_n_i=0 SHALL immediately force state RUN, wait_cnt=0, stall_cnt_o=0 and err_o=0.
REQ-038 While rst_n_i=0, stall_o, flush_o, pc_redirect_o and pc_redirect_addr_o SHALL be 0 regardless of inputs.
REQ-039 Reset asserted mid-MEMWAIT SHALL abandon the wait; after release the block starts in RUN.

Verification
REQ-040 Load-use: exe_is_load_i=1, exe_reg_we_i=1, exe_reg_waddr_i=5, id_reg2_re_i=1, id_reg2_raddr_i=5 -> stall_o=0011, flush_o=10, next state LDUSE, then RUN; stall_cnt_o=1.
REQ-041 Load to x0: same stimulus with waddr=0 -> no stall, no flush.
REQ-042 Jump during hazard: exe_jump_i=1, target 0x80000040, hazard true -> flush_o=11, redirect 0x80000040, FLUSH, then flush_o=01 for one cycle, then RUN.
REQ-043 Memory wait: mem_req_i=1 held 3 cycles, ack on 4th -> stall_o=1111 for 3 cycles, 0 in ack cycle; stall_cnt_o=3.
REQ-044 Timeout: TIMEOUT=4, mem_req_i=1 with no ack -> err_o=1 after 4 MEMWAIT cycles; stays set after ack until rst_n_i=0.
REQ-045 Async reset mid-MEMWAIT: rst_n_i low between clock edges -> outputs 0 immediately, state_o=0, counters 0.
